// File: rtl/mmu_req_arbiter.sv
// Arbitrates fetch and LSU translation requests onto one MMU port, one translation
// in flight at a time, with flush handling and registered per-requester responses.
module mmu_req_arbiter #(
  parameter int VADDR_LEN = 39,
  parameter int PADDR_LEN = 56
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush_i,
  input  logic                 if_req_valid_i,
  output logic                 if_req_ready_o,
  input  logic [VADDR_LEN-1:0] if_req_addr_i,
  output logic                 if_resp_valid_o,
  input  logic                 if_resp_ready_i,
  output logic [PADDR_LEN-1:0] if_resp_addr_o,
  output logic                 if_resp_fault_o,
  output logic [3:0]           if_resp_cause_o,
  input  logic                 lsu_req_valid_i,
  output logic                 lsu_req_ready_o,
  input  logic [VADDR_LEN-1:0] lsu_req_addr_i,
  input  logic [1:0]           lsu_req_mode_i,
  output logic                 lsu_resp_valid_o,
  input  logic                 lsu_resp_ready_i,
  output logic [PADDR_LEN-1:0] lsu_resp_addr_o,
  output logic                 lsu_resp_fault_o,
  output logic [3:0]           lsu_resp_cause_o,
  output logic                 mmu_req_valid_o,
  input  logic                 mmu_req_ready_i,
  output logic [VADDR_LEN-1:0] mmu_req_addr_o,
  output logic [1:0]           mmu_access_mode_o,
  input  logic                 mmu_resp_valid_i,
  output logic                 mmu_resp_ready_o,
  input  logic [PADDR_LEN-1:0] mmu_resp_addr_i,
  input  logic                 mmu_fault_valid_i,
  input  logic [3:0]           mmu_fault_cause_i
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_DRAIN} state_e;
  typedef enum logic {SRC_LSU = 1'b0, SRC_IF = 1'b1} src_e;

  localparam logic [1:0] MODE_EXEC = 2'b10;

  state_e               state_q, state_d;
  src_e                 owner_q, last_grant_q;
  logic [VADDR_LEN-1:0] vaddr_q;
  logic [1:0]           mode_q;
  logic [PADDR_LEN-1:0] paddr_q;
  logic                 fault_q;
  logic [3:0]           cause_q;

  logic grant_if, grant_lsu, capture;
  logic mmu_got, owner_ready;

  assign mmu_got     = mmu_resp_valid_i | mmu_fault_valid_i;
  assign owner_ready = (owner_q == SRC_IF) ? if_resp_ready_i : lsu_resp_ready_i;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d          = state_q;
    grant_if         = 1'b0;
    grant_lsu        = 1'b0;
    capture          = 1'b0;
    mmu_req_valid_o  = 1'b0;
    mmu_resp_ready_o = 1'b0;
    if_resp_valid_o  = 1'b0;
    lsu_resp_valid_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Readies are gated by rstn so nothing is granted while reset is held.
        if (rstn && !flush_i) begin
          if (if_req_valid_i && lsu_req_valid_i) begin
            grant_if  = (last_grant_q == SRC_LSU);
            grant_lsu = (last_grant_q == SRC_IF);
          end else begin
            grant_if  = if_req_valid_i;
            grant_lsu = lsu_req_valid_i;
          end
          if (grant_if || grant_lsu) state_d = S_REQ;
        end
      end
      S_REQ: begin
        mmu_req_valid_o = 1'b1;
        if (flush_i)              state_d = mmu_req_ready_i ? S_DRAIN : S_IDLE;
        else if (mmu_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        mmu_resp_ready_o = 1'b1;
        if (flush_i) begin
          state_d = mmu_got ? S_IDLE : S_DRAIN;
        end else if (mmu_got) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // A flush discards the result, so the requester never sees it complete.
        if_resp_valid_o  = !flush_i && (owner_q == SRC_IF);
        lsu_resp_valid_o = !flush_i && (owner_q == SRC_LSU);
        if (flush_i || owner_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        mmu_resp_ready_o = 1'b1;
        if (mmu_got) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      last_grant_q <= SRC_LSU;
      owner_q      <= SRC_LSU;
      vaddr_q      <= '0;
      mode_q       <= '0;
      paddr_q      <= '0;
      fault_q      <= 1'b0;
      cause_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_if) begin
        owner_q      <= SRC_IF;
        last_grant_q <= SRC_IF;
        vaddr_q      <= if_req_addr_i;
        mode_q       <= MODE_EXEC;
      end else if (grant_lsu) begin
        owner_q      <= SRC_LSU;
        last_grant_q <= SRC_LSU;
        vaddr_q      <= lsu_req_addr_i;
        mode_q       <= lsu_req_mode_i;
      end
      if (capture) begin
        paddr_q <= mmu_resp_addr_i;
        fault_q <= mmu_fault_valid_i;
        cause_q <= mmu_fault_valid_i ? mmu_fault_cause_i : 4'h0;
      end
    end
  end

  assign if_req_ready_o    = grant_if;
  assign lsu_req_ready_o   = grant_lsu;
  assign mmu_req_addr_o    = vaddr_q;
  assign mmu_access_mode_o = mode_q;
  assign if_resp_addr_o    = paddr_q;
  assign if_resp_fault_o   = fault_q;
  assign if_resp_cause_o   = cause_q;
  assign lsu_resp_addr_o   = paddr_q;
  assign lsu_resp_fault_o  = fault_q;
  assign lsu_resp_cause_o  = cause_q;

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// Directed and randomized checks of mmu_req_arbiter against a transaction-level
// model: fair arbitration, MMU handshakes, response routing, flush and reset.
module tb_mmu_req_arbiter;

  localparam int VA = 39;
  localparam int PA = 56;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush_i;
  logic          if_req_valid_i, if_req_ready_o;
  logic [VA-1:0] if_req_addr_i;
  logic          if_resp_valid_o, if_resp_ready_i;
  logic [PA-1:0] if_resp_addr_o;
  logic          if_resp_fault_o;
  logic [3:0]    if_resp_cause_o;
  logic          lsu_req_valid_i, lsu_req_ready_o;
  logic [VA-1:0] lsu_req_addr_i;
  logic [1:0]    lsu_req_mode_i;
  logic          lsu_resp_valid_o, lsu_resp_ready_i;
  logic [PA-1:0] lsu_resp_addr_o;
  logic          lsu_resp_fault_o;
  logic [3:0]    lsu_resp_cause_o;
  logic          mmu_req_valid_o, mmu_req_ready_i;
  logic [VA-1:0] mmu_req_addr_o;
  logic [1:0]    mmu_access_mode_o;
  logic          mmu_resp_valid_i, mmu_resp_ready_o;
  logic [PA-1:0] mmu_resp_addr_i;
  logic          mmu_fault_valid_i;
  logic [3:0]    mmu_fault_cause_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference-model state for the randomized phase.
  bit            if_pend, lsu_pend, busy, req_phase, mmu_wait, resp_avail, cur_if, last_if;
  bit            exp_if_g, exp_lsu_g, exp_fault;
  int            mmu_cnt, kind;
  logic [VA-1:0] if_va, lsu_va, cur_va;
  logic [1:0]    lsu_md, cur_mode;
  logic [PA-1:0] exp_pa;
  logic [3:0]    exp_cause;
  logic [63:0]   rnd;

  mmu_req_arbiter #(.VADDR_LEN(VA), .PADDR_LEN(PA)) dut (
    .clk(clk), .rstn(rstn), .flush_i(flush_i),
    .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o),
    .if_req_addr_i(if_req_addr_i),
    .if_resp_valid_o(if_resp_valid_o), .if_resp_ready_i(if_resp_ready_i),
    .if_resp_addr_o(if_resp_addr_o), .if_resp_fault_o(if_resp_fault_o),
    .if_resp_cause_o(if_resp_cause_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_req_addr_i(lsu_req_addr_i), .lsu_req_mode_i(lsu_req_mode_i),
    .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_ready_i(lsu_resp_ready_i),
    .lsu_resp_addr_o(lsu_resp_addr_o), .lsu_resp_fault_o(lsu_resp_fault_o),
    .lsu_resp_cause_o(lsu_resp_cause_o),
    .mmu_req_valid_o(mmu_req_valid_o), .mmu_req_ready_i(mmu_req_ready_i),
    .mmu_req_addr_o(mmu_req_addr_o), .mmu_access_mode_o(mmu_access_mode_o),
    .mmu_resp_valid_i(mmu_resp_valid_i), .mmu_resp_ready_o(mmu_resp_ready_o),
    .mmu_resp_addr_i(mmu_resp_addr_i),
    .mmu_fault_valid_i(mmu_fault_valid_i), .mmu_fault_cause_i(mmu_fault_cause_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0;
    if_req_valid_i = 1'b0;  if_req_addr_i = '0;  if_resp_ready_i = 1'b0;
    lsu_req_valid_i = 1'b0; lsu_req_addr_i = '0; lsu_req_mode_i = 2'b00; lsu_resp_ready_i = 1'b0;
    mmu_req_ready_i = 1'b0; mmu_resp_valid_i = 1'b0; mmu_resp_addr_i = '0;
    mmu_fault_valid_i = 1'b0; mmu_fault_cause_i = 4'h0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    if_req_valid_i  = 1'b1;
    lsu_req_valid_i = 1'b1;
    #1;
    check("rst if_req_ready", 64'(if_req_ready_o), 64'd0);
    check("rst lsu_req_ready", 64'(lsu_req_ready_o), 64'd0);
    check("rst if_resp_valid", 64'(if_resp_valid_o), 64'd0);
    check("rst lsu_resp_valid", 64'(lsu_resp_valid_o), 64'd0);
    check("rst mmu_req_valid", 64'(mmu_req_valid_o), 64'd0);
    check("rst mmu_resp_ready", 64'(mmu_resp_ready_o), 64'd0);
    check("rst mmu_req_addr", 64'(mmu_req_addr_o), 64'd0);
    check("rst mmu_mode", 64'(mmu_access_mode_o), 64'd0);
    check("rst resp_addr", 64'(if_resp_addr_o), 64'd0);
    check("rst resp_fault", 64'(lsu_resp_fault_o), 64'd0);
    check("rst resp_cause", 64'(lsu_resp_cause_o), 64'd0);
    idle_inputs();
    step();
    step();
    rstn = 1'b1;
  endtask

  function automatic logic [PA-1:0] xlate(input logic [VA-1:0] va);
    return {17'h000A5, va[38:12] ^ 27'h2A55AA5, va[11:0]};
  endfunction

  initial begin
    idle_inputs();
    do_reset();

    // Fetch only, zero-wait MMU: response three cycles after the accept cycle.
    if_req_valid_i = 1'b1; if_req_addr_i = 39'h00_1234_5678;
    mmu_req_ready_i = 1'b1; mmu_resp_valid_i = 1'b1; mmu_resp_addr_i = 56'h80_0000_0678;
    if_resp_ready_i = 1'b1;
    #1;
    check("fetch accept", 64'(if_req_ready_o), 64'd1);
    check("fetch lsu not ready", 64'(lsu_req_ready_o), 64'd0);
    check("fetch mmu_resp_ready idle", 64'(mmu_resp_ready_o), 64'd0);
    step(); if_req_valid_i = 1'b0; #1;
    check("fetch mmu_req_valid", 64'(mmu_req_valid_o), 64'd1);
    check("fetch mmu mode", 64'(mmu_access_mode_o), 64'd2);
    check("fetch mmu addr", 64'(mmu_req_addr_o), 64'h00_1234_5678);
    check("fetch early resp c1", 64'(if_resp_valid_o), 64'd0);
    step(); #1;
    check("fetch wait ready", 64'(mmu_resp_ready_o), 64'd1);
    check("fetch early resp c2", 64'(if_resp_valid_o), 64'd0);
    step(); #1;
    check("fetch resp valid c3", 64'(if_resp_valid_o), 64'd1);
    check("fetch resp addr", 64'(if_resp_addr_o), 64'h80_0000_0678);
    check("fetch resp fault", 64'(if_resp_fault_o), 64'd0);
    check("fetch resp cause", 64'(if_resp_cause_o), 64'd0);
    check("fetch lsu resp quiet", 64'(lsu_resp_valid_o), 64'd0);
    step(); #1;
    check("fetch back idle", 64'(if_resp_valid_o), 64'd0);
    check("fetch no mmu req", 64'(mmu_req_valid_o), 64'd0);

    // Both requesters valid continuously: grants alternate starting with fetch.
    do_reset();
    if_req_valid_i = 1'b1; if_req_addr_i = 39'h11_0000_1000;
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 39'h22_0000_2000; lsu_req_mode_i = 2'b00;
    mmu_req_ready_i = 1'b1; mmu_resp_valid_i = 1'b1; mmu_resp_addr_i = 56'h33_4444;
    if_resp_ready_i = 1'b1; lsu_resp_ready_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      check("tie if grant", 64'(if_req_ready_o), 64'(t % 2 == 0));
      check("tie lsu grant", 64'(lsu_req_ready_o), 64'(t % 2 == 1));
      step(); #1;
      check("tie mmu mode", 64'(mmu_access_mode_o), (t % 2 == 0) ? 64'd2 : 64'd0);
      check("tie no lsu resp in req", 64'(lsu_resp_valid_o), 64'd0);
      step(); step(); #1;
      check("tie if resp owner", 64'(if_resp_valid_o), 64'(t % 2 == 0));
      check("tie lsu resp owner", 64'(lsu_resp_valid_o), 64'(t % 2 == 1));
      step();
    end

    // LSU write hitting a page fault.
    idle_inputs();
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 39'h7F_0000_1000; lsu_req_mode_i = 2'b01;
    mmu_req_ready_i = 1'b1; mmu_fault_valid_i = 1'b1; mmu_fault_cause_i = 4'hF;
    mmu_resp_addr_i = 56'h1; lsu_resp_ready_i = 1'b1;
    #1;
    check("fault lsu accept", 64'(lsu_req_ready_o), 64'd1);
    step(); lsu_req_valid_i = 1'b0; #1;
    check("fault mmu mode", 64'(mmu_access_mode_o), 64'd1);
    check("fault mmu addr", 64'(mmu_req_addr_o), 64'h7F_0000_1000);
    step(); step(); #1;
    check("fault lsu resp valid", 64'(lsu_resp_valid_o), 64'd1);
    check("fault flag", 64'(lsu_resp_fault_o), 64'd1);
    check("fault cause", 64'(lsu_resp_cause_o), 64'hF);
    check("fault if resp quiet", 64'(if_resp_valid_o), 64'd0);
    step();

    // Flush while waiting; late MMU response is drained, then a new grant.
    idle_inputs();
    if_req_valid_i = 1'b1; if_req_addr_i = 39'h01_0000_A000;
    mmu_req_ready_i = 1'b1; if_resp_ready_i = 1'b1;
    #1;
    check("drain accept", 64'(if_req_ready_o), 64'd1);
    step(); if_req_valid_i = 1'b0; #1;
    check("drain mmu req", 64'(mmu_req_valid_o), 64'd1);
    step(); flush_i = 1'b1; #1;
    check("drain wait ready", 64'(mmu_resp_ready_o), 64'd1);
    step(); flush_i = 1'b0;
    if_req_valid_i = 1'b1; if_req_addr_i = 39'h02_0000_B000;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) begin
        mmu_resp_valid_i = 1'b1; mmu_resp_addr_i = 56'hDEAD_0000;
      end
      #1;
      check("drain mmu ready", 64'(mmu_resp_ready_o), 64'd1);
      check("drain no if resp", 64'(if_resp_valid_o), 64'd0);
      check("drain no lsu resp", 64'(lsu_resp_valid_o), 64'd0);
      check("drain no grant", 64'(if_req_ready_o), 64'd0);
      step();
    end
    mmu_resp_valid_i = 1'b0; #1;
    check("drain new grant", 64'(if_req_ready_o), 64'd1);
    check("drain idle mmu ready", 64'(mmu_resp_ready_o), 64'd0);
    step(); if_req_valid_i = 1'b0; mmu_resp_valid_i = 1'b1; mmu_resp_addr_i = 56'hBEEF_0000; #1;
    check("drain new mmu addr", 64'(mmu_req_addr_o), 64'h02_0000_B000);
    step(); step(); #1;
    check("drain new resp valid", 64'(if_resp_valid_o), 64'd1);
    check("drain new resp addr", 64'(if_resp_addr_o), 64'hBEEF_0000);
    step();

    // Owner back-pressure for 10 cycles: payload and handshakes frozen.
    idle_inputs();
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 39'h05_0000_5000;
    mmu_req_ready_i = 1'b1; mmu_resp_valid_i = 1'b1; mmu_resp_addr_i = 56'h00AB_CDEF_0123;
    #1;
    check("stall accept", 64'(lsu_req_ready_o), 64'd1);
    step(); lsu_req_valid_i = 1'b0;
    step(); step();
    if_req_valid_i = 1'b1; if_req_addr_i = 39'h06_0000_6000; lsu_req_valid_i = 1'b1;
    mmu_resp_addr_i = 56'h0011_2233;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall resp valid", 64'(lsu_resp_valid_o), 64'd1);
      check("stall resp addr", 64'(lsu_resp_addr_o), 64'h00AB_CDEF_0123);
      check("stall if_req_ready", 64'(if_req_ready_o), 64'd0);
      check("stall lsu_req_ready", 64'(lsu_req_ready_o), 64'd0);
      check("stall mmu_resp_ready", 64'(mmu_resp_ready_o), 64'd0);
      step();
    end
    lsu_resp_ready_i = 1'b1; #1;
    check("stall release valid", 64'(lsu_resp_valid_o), 64'd1);
    step(); #1;
    check("post stall tie fetch", 64'(if_req_ready_o), 64'd1);
    check("post stall tie lsu", 64'(lsu_req_ready_o), 64'd0);

    // Flush in REQ without MMU ready withdraws the request.
    step(); idle_inputs(); flush_i = 1'b1; #1;
    check("flush req valid", 64'(mmu_req_valid_o), 64'd1);
    check("flush req addr", 64'(mmu_req_addr_o), 64'h06_0000_6000);
    step(); flush_i = 1'b0; #1;
    check("flush req withdrawn", 64'(mmu_req_valid_o), 64'd0);

    // Flush in IDLE blocks grants; flush in RESP discards the result.
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 39'h07_0000_7000; flush_i = 1'b1; #1;
    check("flush idle no grant", 64'(lsu_req_ready_o), 64'd0);
    flush_i = 1'b0; #1;
    check("flush idle grant", 64'(lsu_req_ready_o), 64'd1);
    step(); lsu_req_valid_i = 1'b0; mmu_req_ready_i = 1'b1; mmu_resp_valid_i = 1'b1;
    step(); step(); flush_i = 1'b1; #1;
    check("flush resp hidden", 64'(lsu_resp_valid_o), 64'd0);
    step(); flush_i = 1'b0; lsu_req_valid_i = 1'b1; mmu_resp_valid_i = 1'b0; #1;
    check("flush resp to idle", 64'(lsu_req_ready_o), 64'd1);
    check("flush resp no mmu req", 64'(mmu_req_valid_o), 64'd0);
    // Flush coinciding with the MMU accepting the request goes to DRAIN.
    step(); lsu_req_valid_i = 1'b0; flush_i = 1'b1; #1;
    check("flush req+ready valid", 64'(mmu_req_valid_o), 64'd1);
    step(); flush_i = 1'b0; #1;
    check("flush drain ready", 64'(mmu_resp_ready_o), 64'd1);
    check("flush drain no resp", 64'(lsu_resp_valid_o), 64'd0);
    mmu_fault_valid_i = 1'b1;
    step(); mmu_fault_valid_i = 1'b0; #1;
    check("flush drain exit", 64'(mmu_resp_ready_o), 64'd0);
    check("flush drain no resp2", 64'(lsu_resp_valid_o), 64'd0);

    // Reset pulse during REQ, after fetch was granted last.
    idle_inputs();
    if_req_valid_i = 1'b1; if_req_addr_i = 39'h08_0000_8000; #1;
    check("rstreq accept", 64'(if_req_ready_o), 64'd1);
    step(); if_req_valid_i = 1'b0; #1;
    check("rstreq in req", 64'(mmu_req_valid_o), 64'd1);
    rstn = 1'b0; if_req_valid_i = 1'b1; lsu_req_valid_i = 1'b1; #1;
    check("rstreq valid drops", 64'(mmu_req_valid_o), 64'd0);
    check("rstreq addr cleared", 64'(mmu_req_addr_o), 64'd0);
    check("rstreq no if grant", 64'(if_req_ready_o), 64'd0);
    check("rstreq no lsu grant", 64'(lsu_req_ready_o), 64'd0);
    step(); rstn = 1'b1; #1;
    check("rstreq tie fetch", 64'(if_req_ready_o), 64'd1);
    check("rstreq tie lsu", 64'(lsu_req_ready_o), 64'd0);

    // Randomized traffic against a transaction-level model.
    do_reset();
    if_pend = 0; lsu_pend = 0; busy = 0; req_phase = 0; mmu_wait = 0;
    resp_avail = 0; cur_if = 0; last_if = 0; mmu_cnt = 0;
    exp_pa = '0; exp_fault = 0; exp_cause = '0; cur_va = '0; cur_mode = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1; rnd = {$urandom(), $urandom()}; if_va = rnd[VA-1:0];
      end
      if (!lsu_pend && $urandom_range(0, 2) != 0) begin
        lsu_pend = 1; rnd = {$urandom(), $urandom()}; lsu_va = rnd[VA-1:0];
        lsu_md = 2'($urandom_range(0, 1));
      end
      if_req_valid_i = if_pend;   if_req_addr_i = if_va;
      lsu_req_valid_i = lsu_pend; lsu_req_addr_i = lsu_va; lsu_req_mode_i = lsu_md;
      mmu_req_ready_i = 1'($urandom_range(0, 1));
      rnd = {$urandom(), $urandom()};
      mmu_resp_valid_i = 1'b0; mmu_fault_valid_i = 1'b0;
      mmu_resp_addr_i = rnd[PA-1:0]; mmu_fault_cause_i = rnd[63:60];
      if (mmu_wait && mmu_cnt == 0) begin
        kind = int'($urandom_range(0, 2));
        mmu_resp_valid_i = (kind != 1);
        mmu_fault_valid_i = (kind != 0);
        mmu_resp_addr_i = xlate(cur_va);
        exp_pa = xlate(cur_va);
        exp_fault = (kind != 0);
        exp_cause = exp_fault ? mmu_fault_cause_i : 4'h0;
      end
      if_resp_ready_i = 1'($urandom_range(0, 1));
      lsu_resp_ready_i = 1'($urandom_range(0, 1));
      #1;
      exp_if_g  = !busy && if_pend && (!lsu_pend || !last_if);
      exp_lsu_g = !busy && lsu_pend && (!if_pend || last_if);
      check("rnd if_req_ready", 64'(if_req_ready_o), 64'(exp_if_g));
      check("rnd lsu_req_ready", 64'(lsu_req_ready_o), 64'(exp_lsu_g));
      check("rnd mmu_req_valid", 64'(mmu_req_valid_o), 64'(req_phase));
      check("rnd mmu_resp_ready", 64'(mmu_resp_ready_o), 64'(mmu_wait));
      check("rnd if_resp_valid", 64'(if_resp_valid_o), 64'(resp_avail && cur_if));
      check("rnd lsu_resp_valid", 64'(lsu_resp_valid_o), 64'(resp_avail && !cur_if));
      if (req_phase) begin
        check("rnd mmu addr", 64'(mmu_req_addr_o), 64'(cur_va));
        check("rnd mmu mode", 64'(mmu_access_mode_o), 64'(cur_mode));
      end
      if (resp_avail) begin
        check("rnd resp addr", cur_if ? 64'(if_resp_addr_o) : 64'(lsu_resp_addr_o), 64'(exp_pa));
        check("rnd resp fault", cur_if ? 64'(if_resp_fault_o) : 64'(lsu_resp_fault_o), 64'(exp_fault));
        check("rnd resp cause", cur_if ? 64'(if_resp_cause_o) : 64'(lsu_resp_cause_o), 64'(exp_cause));
      end
      if (resp_avail && (cur_if ? if_resp_ready_i : lsu_resp_ready_i)) begin
        resp_avail = 0; busy = 0;
      end
      if (mmu_wait) begin
        if (mmu_cnt == 0) begin
          mmu_wait = 0; resp_avail = 1;
        end else begin
          mmu_cnt--;
        end
      end
      if (req_phase && mmu_req_ready_i) begin
        req_phase = 0; mmu_wait = 1; mmu_cnt = int'($urandom_range(0, 3));
      end
      if (exp_if_g) begin
        busy = 1; req_phase = 1; cur_if = 1; last_if = 1;
        cur_va = if_va; cur_mode = 2'b10; if_pend = 0;
      end else if (exp_lsu_g) begin
        busy = 1; req_phase = 1; cur_if = 0; last_if = 0;
        cur_va = lsu_va; cur_mode = lsu_md; lsu_pend = 0;
      end
      step();
    end

    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_req_arbiter.md
MMU_REQ_ARBITER -- requirements
Module: mmu_req_arbiter

Interface
REQ-001 Parameters: VADDR_LEN, default 39, virtual address width; PADDR_LEN, default 56, physical address width.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 flush_i  in  1  pipeline flush; abandons the in-flight translation.
REQ-005 if_req_valid_i / if_req_ready_o  in/out  1/1  fetch request handshake.
REQ-006 if_req_addr_i  in  VADDR_LEN  fetch virtual address.
REQ-007 if_resp_valid_o / if_resp_ready_i  out/in  1/1  fetch response handshake.
REQ-008 if_resp_addr_o  out  PADDR_LEN; if_resp_fault_o  out  1; if_resp_cause_o  out  4  fetch result.
REQ-009 lsu_req_valid_i / lsu_req_ready_o  in/out  1/1  LSU request handshake.
REQ-010 lsu_req_addr_i  in  VADDR_LEN; lsu_req_mode_i  in  2  (00 read, 01 write).
REQ-011 lsu_resp_valid_o / lsu_resp_ready_i  out/in  1/1; lsu_resp_addr_o  out  PADDR_LEN; lsu_resp_fault_o  out  1; lsu_resp_cause_o  out  4.
REQ-012 mmu_req_valid_o / mmu_req_ready_i  out/in  1/1; mmu_req_addr_o  out  VADDR_LEN; mmu_access_mode_o  out  2.
REQ-013 mmu_resp_valid_i / mmu_resp_ready_o  in/out  1/1; mmu_resp_addr_i  in  PADDR_LEN.
REQ-014 mmu_fault_valid_i  in  1; mmu_fault_cause_i  in  4  MMU page-fault report.

Function
REQ-015 FSM states IDLE, REQ, WAIT, RESP, DRAIN; one translation outstanding at a time.
REQ-016 IDLE: if_req_ready_o/lsu_req_ready_o asserted combinationally only for the granted requester and only when flush_i=0; all other states hold both readies at 0.
REQ-017 Arbitration: single requester wins; both valid -> requester not granted last wins; last-grant register resets to LSU, so fetch wins the first tie.
REQ-018 On accept, capture address, owner and mode (fetch forces 10 execute; LSU passes lsu_req_mode_i); next state REQ.
REQ-019 REQ: mmu_req_valid_o=1 with captured address/mode, held stable until mmu_req_ready_i=1; then -> WAIT.
REQ-020 WAIT: mmu_resp_ready_o=1; mmu_resp_valid_i=1 or mmu_fault_valid_i=1 captures addr, fault flag, cause (cause zeroed when no fault); -> RESP.
REQ-021 Both mmu_resp_valid_i and mmu_fault_valid_i in one cycle: fault takes priority, fault=1.
REQ-022 RESP: owner's resp_valid_o=1 with registered payload; other requester's resp_valid_o=0; held until owner ready; handshake -> IDLE.
REQ-023 Minimum latency accept -> owner resp_valid_o: 3 cycles (REQ, WAIT, RESP) with zero-wait MMU.
REQ-024 Next request is accepted no earlier than the cycle after the RESP handshake (IDLE cycle).
REQ-025 flush_i in IDLE: no grant. In REQ with mmu_req_ready_i=1 same cycle: -> DRAIN; otherwise -> IDLE, request withdrawn.
REQ-026 flush_i in WAIT: -> DRAIN, unless MMU response/fault arrives the same cycle -> IDLE (response discarded). In RESP: response discarded, -> IDLE.
REQ-027 DRAIN: mmu_resp_ready_o=1, no owner response; response or fault -> IDLE; further flush_i keeps DRAIN.
REQ-028 mmu_resp_ready_o=0 in IDLE, REQ, RESP.
REQ-029 Payload outputs are registered; no combinational path from MMU inputs to requester outputs.

Reset
REQ-030 rstn=0 forces state IDLE, last-grant=LSU, all valid/ready outputs 0, payload registers 0, asynchronously, including mid-translation.
REQ-031 First rising edge after rstn deasserts may accept a request.

Verification
REQ-032 Fetch only, addr 0x00_1234_5678, MMU ready/resp immediate with 0x80_0000_0678 -> mmu_access_mode_o=10, if_resp_valid_o 3 cycles after accept, addr 0x80_0000_0678, fault 0.
REQ-033 Both valid continuously, 4 transactions -> grant order fetch, LSU, fetch, LSU; lsu_resp_valid_o never asserted for fetch-owned results.
REQ-034 LSU write, MMU fault cause 0xF -> lsu_resp_fault_o=1, lsu_resp_cause_o=0xF, mode 01 presented to MMU.
REQ-035 flush_i in WAIT, MMU responds 5 cycles later -> DRAIN consumes it, no requester resp_valid, then IDLE and new grant accepted.
REQ-036 Owner resp_ready held 0 for 10 cycles -> payload stable, both req_ready_o=0, mmu_resp_ready_o=0 throughout.
REQ-037 rstn pulsed low during REQ -> mmu_req_valid_o drops immediately, state IDLE, next tie granted to fetch.
